// File: rtl/dcache_miss_fsm.sv
// Purpose: dcache controller; sequences the 2-way/16-set SRAM and the memory port (hit, writeback, refill, fill).
// Latency: hits are combinational, zero stall; clean miss stalls 1 + refill + 1 cycles, dirty miss adds the writeback phase.
// Backpressure: cpu_stall_o holds the CPU for the whole miss; mem_req_o held until mem_ack_i. Optional counters: DCACHE_STATS_EN.
module dcache_miss_fsm #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int LINE_W  = 256,
  parameter int WORD_W  = 32,
  parameter int TAG_W   = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_data_i,
  output logic [WORD_W-1:0]    cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 sram_enable_o,
  output logic                 sram_write_o,
  output logic [INDEX_W-1:0]   sram_index_o,
  output logic [TAG_W+1:0]     sram_tag_o,
  output logic [LINE_W-1:0]    sram_data_o,
  input  logic [TAG_W+1:0]     sram_tag_i,
  input  logic [LINE_W-1:0]    sram_data_i,
  input  logic                 sram_hit_i,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_W-1:0]    mem_data_o,
  input  logic [LINE_W-1:0]    mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]          hit_cnt_o,
  output logic [15:0]          miss_cnt_o,
  output logic [15:0]          wb_cnt_o
`endif
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int SEL_W  = $clog2(LINE_W / WORD_W);
  localparam int LINE_A = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, WB, REFILL, FILL} state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    victim_tag_q;
  logic [LINE_W-1:0]   victim_line_q;
  logic [LINE_W-1:0]   refill_line_q;
  logic [LINE_A-1:0]   req_line_q;
  logic                miss_start;

  logic [SEL_W-1:0]    word_sel;
  logic [TAG_W-1:0]    cpu_tag;
  logic [LINE_W-1:0]   merged_line;
  logic                unused_addr_bits;

  assign word_sel         = cpu_addr_i[OFF_W-1 -: SEL_W];
  assign cpu_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign sram_index_o     = cpu_addr_i[OFF_W+INDEX_W-1:OFF_W];
  assign unused_addr_bits = ^cpu_addr_i[OFF_W-SEL_W-1:0];

  // Store-hit line: SRAM line with the addressed word replaced by store data
  always_comb begin
    merged_line = sram_data_i;
    merged_line[word_sel*WORD_W +: WORD_W] = cpu_data_i;
  end

  // Next-state and all SRAM/memory/CPU outputs
  always_comb begin
    state_d       = state_q;
    miss_start    = 1'b0;
    cpu_stall_o   = 1'b0;
    cpu_data_o    = sram_data_i[word_sel*WORD_W +: WORD_W];
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_tag_o    = {1'b1, cpu_write_i, cpu_tag};
    sram_data_o   = merged_line;
    mem_req_o     = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    case (state_q)
      IDLE: begin
        sram_enable_o = cpu_req_i;
        if (cpu_req_i) begin
          if (sram_hit_i) begin
            // store hit: tag already carries dirty=1 from cpu_write_i
            sram_write_o = cpu_write_i;
          end else begin
            cpu_stall_o = 1'b1;
            miss_start  = 1'b1;
            // victim valid & dirty -> write it back before refilling
            state_d = (sram_tag_i[TAG_W+1] && sram_tag_i[TAG_W]) ? WB : REFILL;
          end
        end
      end
      WB: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {victim_tag_q, sram_index_o, {OFF_W{1'b0}}};
        mem_data_o  = victim_line_q;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {req_line_q, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = FILL;
      end
      FILL: begin
        // SRAM places the clean line in the LRU way; next cycle re-looks up as a hit
        cpu_stall_o   = 1'b1;
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        sram_tag_o    = {1'b1, 1'b0, req_line_q[LINE_A-1 -: TAG_W]};
        sram_data_o   = refill_line_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus miss bookkeeping (victim, request line, refill data)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      victim_tag_q  <= '0;
      victim_line_q <= '0;
      refill_line_q <= '0;
      req_line_q    <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        victim_tag_q  <= sram_tag_i[TAG_W-1:0];
        victim_line_q <= sram_data_i;
        req_line_q    <= cpu_addr_i[ADDR_W-1:OFF_W];
      end
      if (state_q == REFILL && mem_ack_i) refill_line_q <= mem_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic hit_evt, wb_evt;
  assign hit_evt = (state_q == IDLE) && cpu_req_i && sram_hit_i;
  assign wb_evt  = (state_q == WB) && mem_ack_i;

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (hit_evt && hit_cnt_o != 16'hFFFF)    hit_cnt_o  <= hit_cnt_o + 16'd1;
      if (miss_start && miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
      if (wb_evt && wb_cnt_o != 16'hFFFF)      wb_cnt_o   <= wb_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_fsm.sv
// Bench for dcache_miss_fsm: behavioural 2-way LRU SRAM, delayed-ack memory, and a flat golden memory.
// Every load result and writeback line is checked against the golden memory; stall lengths against miss rules.
// Counter checks are compiled only when DCACHE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_dcache_miss_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, sram_enable_o, sram_write_o;
  logic [3:0]   sram_index_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_hit_i;
  logic         mem_req_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
  logic [15:0]  hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

  dcache_miss_fsm dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_index_o(sram_index_o),
    .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
    .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- golden architectural memory ----------------
  logic [31:0]  golden  [logic [31:0]];
  logic [255:0] backing [logic [31:0]];

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (golden.exists(k)) return golden[k];
    return 32'hA500_0000 | k;
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_word(la + 32'(w*4));
    return l;
  endfunction

  function automatic logic [255:0] pattern_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA500_0000 | (la + 32'(w*4));
    return l;
  endfunction

  // ---------------- behavioural SRAM (2-way, LRU) ----------------
  logic         tb_init;
  logic [24:0]  s_tag [16][2];
  logic [255:0] s_dat [16][2];
  logic         s_lru [16];
  int           sram_writes = 0;
  int           hw;

  always_comb begin
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (s_tag[sram_index_o][w][24] && s_tag[sram_index_o][w][22:0] == sram_tag_o[22:0]) hw = w;
    sram_hit_i = sram_enable_o && (hw >= 0);
    if (hw >= 0) begin
      sram_tag_i  = s_tag[sram_index_o][hw];
      sram_data_i = s_dat[sram_index_o][hw];
    end else begin
      sram_tag_i  = s_tag[sram_index_o][s_lru[sram_index_o]];
      sram_data_i = s_dat[sram_index_o][s_lru[sram_index_o]];
    end
  end

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 16; i++) begin
        s_lru[i] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          s_tag[i][w] <= '0;
          s_dat[i][w] <= '0;
        end
      end
    end else if (sram_enable_o) begin
      if (sram_write_o) begin
        sram_writes <= sram_writes + 1;
        if (hw >= 0) begin
          s_tag[sram_index_o][hw] <= sram_tag_o;
          s_dat[sram_index_o][hw] <= sram_data_o;
          s_lru[sram_index_o]     <= (hw == 0);
        end else begin
          s_tag[sram_index_o][s_lru[sram_index_o]] <= sram_tag_o;
          s_dat[sram_index_o][s_lru[sram_index_o]] <= sram_data_o;
          s_lru[sram_index_o] <= ~s_lru[sram_index_o];
        end
      end else if (hw >= 0) begin
        s_lru[sram_index_o] <= (hw == 0);
      end
    end
  end

  function automatic bit model_hit(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (s_tag[a[8:5]][w][24] && s_tag[a[8:5]][w][22:0] == a[31:9]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_dirty_victim(input logic [31:0] a);
    logic [24:0] t;
    t = s_tag[a[8:5]][s_lru[a[8:5]]];
    return t[24] & t[23];
  endfunction

  // ---------------- memory responder: ack on the Nth cycle of a request ----------------
  int           ack_delay = 3;
  bit           manual    = 1'b0;
  int           wb_seen   = 0;
  logic [31:0]  last_wb_addr = '0, last_rd_addr = '0;
  logic [255:0] last_wb_line = '0;

  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (manual) begin
        cnt = 0;
      end else begin
        mem_ack_i = 1'b0;
        if (mem_req_o && !rst_i) begin
          cnt++;
          if (cnt >= ack_delay) begin
            cnt = 0;
            mem_ack_i = 1'b1;
            if (mem_write_o) begin
              backing[mem_addr_o] = mem_data_o;
              wb_seen++;
              last_wb_addr = mem_addr_o;
              last_wb_line = mem_data_o;
            end else begin
              mem_data_i   = backing.exists(mem_addr_o) ? backing[mem_addr_o] : pattern_line(mem_addr_o);
              last_rd_addr = mem_addr_o;
            end
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the golden memory ----------------
  always @(negedge clk) begin
    if (!rst_i && !tb_init) begin
      if (cpu_req_i && !cpu_stall_o && !cpu_write_i)
        chk("load_data", cpu_data_o, gold_word(cpu_addr_i));
      if (mem_req_o) begin
        chk("mem_addr_align", mem_addr_o[4:0], 5'd0);
        chk("no_sram_write_during_mem", sram_write_o, 1'b0);
      end
      if (mem_req_o && mem_write_o)
        chk("wb_line", mem_data_o, gold_line(mem_addr_o));
    end
  end

  // ---------------- CPU access: call at posedge+1, returns at posedge+1 ----------------
  task automatic access(input logic [31:0] a, input bit wr, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdata,
                        output logic [24:0] tag_seen, output logic [255:0] dat_seen, output bit wr_seen);
    bit exp_hit, exp_dirty;
    int wb0;
    exp_hit   = model_hit(a);
    exp_dirty = model_dirty_victim(a);
    wb0       = wb_seen;
    cpu_addr_i = a; cpu_write_i = wr; cpu_data_i = d; cpu_req_i = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (cpu_stall_o && stalls < 500) begin
      stalls++;
      @(negedge clk);
    end
    if (cpu_stall_o) chk("stall_timeout", cpu_stall_o, 1'b0);
    rdata    = cpu_data_o;
    tag_seen = sram_tag_o;
    dat_seen = sram_data_o;
    wr_seen  = sram_write_o;
    if (wr) golden[{a[31:2], 2'b00}] = d;
    if (exp_hit) chk("hit_no_stall", 32'(stalls), 32'd0);
    else if (!exp_dirty) chk("clean_miss_stall", 32'(stalls), 32'(ack_delay + 2));
    chk("wb_count", 32'(wb_seen - wb0), (!exp_hit && exp_dirty) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    cpu_req_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, w0;
    logic [31:0] rd;
    logic [24:0] tg;
    logic [255:0] dt;
    bit wrs;
    tb_init = 1'b1; rst_i = 1'b1;
    cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    repeat (3) @(posedge clk);
    #1 tb_init = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_write", mem_write_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_sram_write", sram_write_o, 1'b0);
    chk("rst_sram_enable", sram_enable_o, 1'b0);
    @(posedge clk); #1;

    // cold load 0x40, ack on 3rd request cycle
    ack_delay = 3;
    access(32'h40, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    chk("t1_stall", 32'(st), 32'd5);
    chk("t1_refill_addr", last_rd_addr, 32'h40);
    chk("t1_data", rd, 32'hA500_0040);

    // store hit 0x44
    access(32'h44, 1'b1, 32'hDEADBEEF, st, rd, tg, dt, wrs);
    chk("t2_stall", 32'(st), 32'd0);
    chk("t2_sram_write", wrs, 1'b1);
    chk("t2_tag", tg, 25'h180_0000);
    chk("t2_word1", dt[63:32], 32'hDEADBEEF);
    chk("t2_word0", dt[31:0], 32'hA500_0040);

    // fill other way of set 2, then evict the dirty LRU line
    ack_delay = 2;
    access(32'h240, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    chk("t3_clean_stall", 32'(st), 32'd4);
    chk("t3_data_240", rd, 32'hA500_0240);
    access(32'h440, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    chk("t3_wb_addr", last_wb_addr, 32'h40);
    chk("t3_wb_word1", last_wb_line[63:32], 32'hDEADBEEF);
    chk("t3_refill_addr", last_rd_addr, 32'h440);
    chk("t3_data_440", rd, 32'hA500_0440);
    access(32'h44, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    chk("t3_reload_dirty", rd, 32'hDEADBEEF);

    // reset during REFILL, ack in the following cycle
    manual = 1'b1; mem_ack_i = 1'b0;
    cpu_addr_i = 32'h840; cpu_write_i = 1'b0; cpu_req_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_in_refill", {mem_req_o, mem_write_o}, 2'b10);
    w0 = sram_writes;
    @(posedge clk); #1 rst_i = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0; mem_ack_i = 1'b1;
    @(negedge clk);
    chk("t4_req_dropped", mem_req_o, 1'b0);
    chk("t4_no_stall", cpu_stall_o, 1'b0);
    @(posedge clk); #1 mem_ack_i = 1'b0;
    @(negedge clk);
    chk("t4_ack_ignored", {mem_req_o, cpu_stall_o, sram_write_o}, 3'b000);
    chk("t4_no_sram_write", 32'(sram_writes), 32'(w0));
    // reset and ack in the same cycle
    @(posedge clk); #1 cpu_req_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4b_in_refill", mem_req_o, 1'b1);
    w0 = sram_writes;
    @(posedge clk); #1 rst_i = 1'b1; mem_ack_i = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    chk("t4b_idle", {mem_req_o, cpu_stall_o, sram_write_o}, 3'b000);
    @(posedge clk); #1;
    chk("t4b_no_sram_write", 32'(sram_writes), 32'(w0));

    // spurious ack while idle
    mem_ack_i = 1'b1;
    @(negedge clk);
    chk("t5_idle_sram_off", sram_enable_o, 1'b0);
    @(posedge clk); #1 mem_ack_i = 1'b0;
    @(negedge clk);
    chk("t5_no_state_change", {mem_req_o, cpu_stall_o}, 2'b00);
    @(posedge clk); #1 manual = 1'b0;
    // ack in the first REFILL cycle
    ack_delay = 1;
    access(32'h1000, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    chk("t5_fast_stall", 32'(st), 32'd3);
    chk("t5_data", rd, 32'hA500_1000);
    access(32'h2000, 1'b0, 32'h0, st, rd, tg, dt, wrs);

`ifdef DCACHE_STATS_EN
    rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("t6_cnt_reset", {hit_cnt_o, miss_cnt_o, wb_cnt_o}, 48'd0);
    @(posedge clk); #1;
    ack_delay = 2;
    access(32'h1004, 1'b1, 32'h1234_5678, st, rd, tg, dt, wrs);
    access(32'h2000, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    access(32'h2004, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    access(32'h3000, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    @(negedge clk);
    chk("t6_hit_cnt", hit_cnt_o, 16'd4);
    chk("t6_miss_cnt", miss_cnt_o, 16'd1);
    chk("t6_wb_cnt", wb_cnt_o, 16'd1);
    @(posedge clk); #1;
    cpu_addr_i = 32'h2000; cpu_write_i = 1'b0; cpu_req_i = 1'b1;
    repeat (65535) @(posedge clk);
    #1 cpu_req_i = 1'b0;
    @(negedge clk);
    chk("t6_hit_sat", hit_cnt_o, 16'hFFFF);
    @(posedge clk); #1;
    access(32'h2000, 1'b0, 32'h0, st, rd, tg, dt, wrs);
    @(negedge clk);
    chk("t6_hit_sat_hold", hit_cnt_o, 16'hFFFF);
    chk("t6_miss_hold", miss_cnt_o, 16'd1);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
